// File: rtl/pid_pkg.sv
// Shared constants and types for the PID channel scheduler and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pid_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int CHN_WIDTH  = 3;
   localparam int NUM_CHN    = 4;
   localparam int TMO_CYCLES = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sched_state_t;

   // Channel index reached by stepping 'off' places past 'ptr', wrapping modulo 4.
   function automatic logic [1:0] rr_offset(input logic [1:0] ptr, input logic [1:0] off);
      return ptr + off;
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester strictly after ptr, ptr itself last.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller qualifies gnt_any with its own ready.
// Ports: req - request vector, ptr - last granted index,
//        gnt_idx - selected index (valid when gnt_any), gnt_any - any request present.
module rr_arbiter4
   import pid_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_idx,
   output logic       gnt_any
);

   // Walk from the farthest offset down to the nearest so the closest
   // requester after ptr is the last (winning) assignment.
   always_comb begin
      gnt_idx = ptr;
      for (int off = 4; off >= 1; off--) begin
         if (req[rr_offset(ptr, 2'(off))]) begin
            gnt_idx = rr_offset(ptr, 2'(off));
         end
      end
   end

   assign gnt_any = |req;

endmodule

// File: rtl/pid_chn_scheduler.sv
// Time-shares one PID core across four motor channels, round-robin, one transaction in flight.
// Latency: sample strobe at edge k -> grant at k+1 -> data_valid_o high after edge k+2.
// Backpressure: tready_i low in IDLE stalls grants; a result (or timeout) is required before the next issue.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   rpm_valid_i/rpm_data_i   - per-channel feedback sample strobes and packed samples
//   tr_valid_i/chn/data      - speed reference write from the UART command path
//   stop_i                   - per-channel stop, excludes channel from scheduling
//   tready_i, u_valid_i/chn  - PID core ready and result strobe
//   data_valid_o/chn/fdb/ref - transaction to the PID core (fields held until next grant)
//   busy_o, ovr_o, tmo_o     - in-flight flag, sticky sample overrun, timeout pulse
module pid_chn_scheduler #(
   parameter int DATA_WIDTH = pid_pkg::DATA_WIDTH,
   parameter int CHN_WIDTH  = pid_pkg::CHN_WIDTH,
   parameter int NUM_CHN    = pid_pkg::NUM_CHN,
   parameter int TMO_CYCLES = pid_pkg::TMO_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CHN-1:0]        rpm_valid_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
   input  logic                      tr_valid_i,
   input  logic [CHN_WIDTH-1:0]      tr_chn_i,
   input  logic [DATA_WIDTH-1:0]     tr_data_i,
   input  logic [NUM_CHN-1:0]        stop_i,
   input  logic                      tready_i,
   input  logic                      u_valid_i,
   input  logic [CHN_WIDTH-1:0]      u_chn_i,
   output logic                      data_valid_o,
   output logic [CHN_WIDTH-1:0]      data_chn_o,
   output logic [DATA_WIDTH-1:0]     data_fdb_o,
   output logic [DATA_WIDTH-1:0]     data_ref_o,
   output logic                      busy_o,
   output logic [NUM_CHN-1:0]        ovr_o,
   output logic                      tmo_o
);
   import pid_pkg::*;

   localparam int                   TW        = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
   localparam logic [TW-1:0]        TMO_LAST  = TW'(TMO_CYCLES - 1);
   localparam logic [CHN_WIDTH-1:0] CHN_LIMIT = CHN_WIDTH'(NUM_CHN);

   sched_state_t          state;
   logic [1:0]            rr_ptr;
   logic [TW-1:0]         tmo_cnt;
   logic [DATA_WIDTH-1:0] smp   [NUM_CHN];
   logic [DATA_WIDTH-1:0] ref_q [NUM_CHN];
   logic [NUM_CHN-1:0]    pend;
   logic [NUM_CHN-1:0]    elig;
   logic [NUM_CHN-1:0]    grant_vec;
   logic [1:0]            arb_idx;
   logic                  arb_any;
   logic                  grant;
   logic                  u_match;
   logic                  ref_wr;

   // Stopped channels never compete, even if a stale pend bit were present.
   assign elig = pend & ~stop_i;

   rr_arbiter4 u_rr_arbiter4 (
      .req     (elig),
      .ptr     (rr_ptr),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   assign grant     = (state == IDLE) && arb_any && tready_i;
   assign grant_vec = grant ? (NUM_CHN'(1) << arb_idx) : '0;
   assign u_match   = u_valid_i && (u_chn_i == data_chn_o);
   assign ref_wr    = tr_valid_i && (tr_chn_i < CHN_LIMIT);
   assign busy_o    = (state != IDLE);

   // Sample capture. A strobe on the channel being granted this cycle is not
   // an overrun: the grant consumes the old sample and the new one stays pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend  <= '0;
         ovr_o <= '0;
         for (int n = 0; n < NUM_CHN; n++) begin
            smp[n] <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_CHN; n++) begin
            if (stop_i[n]) begin
               pend[n] <= 1'b0;
            end else if (rpm_valid_i[n]) begin
               smp[n]  <= rpm_data_i[n*DATA_WIDTH +: DATA_WIDTH];
               pend[n] <= 1'b1;
               if (pend[n] && !grant_vec[n]) begin
                  ovr_o[n] <= 1'b1;
               end
            end else if (grant_vec[n]) begin
               pend[n] <= 1'b0;
            end
         end
      end
   end

   // Reference registers; out-of-range channel writes are dropped. A write in
   // the grant cycle lands after the grant has already sampled the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NUM_CHN; n++) begin
            ref_q[n] <= '0;
         end
      end else if (ref_wr) begin
         ref_q[tr_chn_i[1:0]] <= tr_data_i;
      end
   end

   // Scheduler FSM. data_valid_o and tmo_o are registered one-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= 2'd3;
         tmo_cnt      <= '0;
         data_valid_o <= 1'b0;
         data_chn_o   <= '0;
         data_fdb_o   <= '0;
         data_ref_o   <= '0;
         tmo_o        <= 1'b0;
      end else begin
         data_valid_o <= 1'b0;
         tmo_o        <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  data_chn_o <= CHN_WIDTH'(arb_idx);
                  data_fdb_o <= smp[arb_idx];
                  data_ref_o <= ref_q[arb_idx];
                  rr_ptr     <= arb_idx;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               data_valid_o <= 1'b1;
               tmo_cnt      <= '0;
               state        <= WAIT;
            end
            WAIT: begin
               // A matching result in the final counter cycle wins over the timeout.
               if (u_match) begin
                  state <= IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_o <= 1'b1;
                  state <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pid_chn_scheduler.md
Name: pid_chn_scheduler

Overview:
- Time-shares the single 3p3z PID core between the four motor channels.
- Captures each RPM reader's feedback sample and holds a per-channel speed reference written from the UART command path.
- Grants channels round-robin and issues one data transaction at a time into the PID core.
- Allows one outstanding transaction: waits for the matching u_valid before the next issue, with a timeout as a backstop.

Parameters:
- DATA_WIDTH, 16, width of RPM samples, references and PID output
- CHN_WIDTH, 3, width of channel index fields
- NUM_CHN, 4, number of motor channels (fixed at 4 for this revision)
- TMO_CYCLES, 1024, maximum WAIT cycles for a PID result before abandoning the transaction

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rpm_valid_i  in  4  one-cycle sample strobe per RPM reader, bit n = channel n
- rpm_data_i  in  4*DATA_WIDTH  packed samples, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
- tr_valid_i  in  1  reference write strobe from UART controller
- tr_chn_i  in  CHN_WIDTH  reference channel
- tr_data_i  in  DATA_WIDTH  reference value
- stop_i  in  4  per-channel stop; a stopped channel is never scheduled
- tready_i  in  1  PID core ready
- u_valid_i  in  1  PID result strobe
- u_chn_i  in  CHN_WIDTH  PID result channel
- data_valid_o  out  1  transaction strobe to PID core
- data_chn_o  out  CHN_WIDTH  granted channel
- data_fdb_o  out  DATA_WIDTH  feedback (latched RPM sample)
- data_ref_o  out  DATA_WIDTH  reference of granted channel
- busy_o  out  1  high in ISSUE or WAIT
- ovr_o  out  4  sticky per-channel sample overrun
- tmo_o  out  1  one-cycle pulse on timeout

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all outputs are 0, ref[] = 0, smp[] = 0, pend = 0, state = IDLE, RR pointer = 3 (so channel 0 is checked first).
- Sample capture:
  - rpm_valid_i[n] loads smp[n] and sets pend[n]; pend is visible the following cycle.
  - If pend[n] is already 1 and channel n is not being granted that cycle, the sample is overwritten and ovr_o[n] is set. ovr_o clears only on rst.
  - If capture coincides with the grant of channel n, the grant uses the old smp, and the new sample stays pending with no overrun.
- Stop: while stop_i[n] = 1, pend[n] is forced to 0, captured samples are discarded, and ovr_o is not set. A stop asserted during ISSUE or WAIT does not abort the current transaction.
- Reference write: tr_valid_i with tr_chn_i < 4 writes ref[tr_chn_i]; tr_chn_i >= 4 is ignored. A write coinciding with the grant of the same channel takes effect for the next transaction, not the current one.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: elig = pend & ~stop_i. If elig != 0 and tready_i = 1, grant the first eligible channel after the RR pointer (modulo 4). On grant:
    - register data_chn_o, data_fdb_o = smp, data_ref_o = ref
    - clear pend for the granted channel
    - RR pointer = granted channel
    - go to ISSUE
  - ISSUE: data_valid_o = 1 for exactly this one cycle; go to WAIT, clear the timeout counter.
  - WAIT:
    - If u_valid_i = 1 and u_chn_i == data_chn_o, go to IDLE.
    - A u_valid_i with a mismatched channel is ignored.
    - If the counter reaches TMO_CYCLES-1 first, pulse tmo_o and go to IDLE.
    - A matching u_valid_i in the timeout cycle takes priority and tmo_o is not pulsed.
- Latency:
  - rpm_valid_i at edge k with IDLE and tready_i high: grant at edge k+1, data_valid_o high in the cycle after edge k+2.
  - Minimum spacing between issues is 3 cycles (ISSUE, WAIT with u_valid, IDLE).
- Output hold: data_chn_o, data_fdb_o and data_ref_o hold their values until the next grant. busy_o = (state != IDLE).
- tready_i low in IDLE stalls scheduling; pending samples keep updating, with overrun rules applying.

Decomposition:
- Shared package pid_pkg:
  - DATA_WIDTH, CHN_WIDTH, NUM_CHN
  - state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2
  - default TMO_CYCLES
- One natural sub-module: rr_arbiter4, combinational round-robin pick.
  - Inputs: 4-bit request vector and 2-bit pointer.
  - Outputs: grant index and any-grant flag.
  - Reused by future parameter-load sequencing.

Test Plan:
- Reset behaviour: hold rst for 2 cycles mid-WAIT -> all outputs 0 and state IDLE next cycle; a later rpm_valid_i[0] = 1 with data 16'h0123 issues chn 0, fdb 16'h0123.
- Ref write then sample: tr_valid_i chn 2, data 16'h0300, then rpm_valid_i[2] data 16'h0280, tready_i = 1 -> data_valid_o two cycles after the strobe with chn 2, fdb 16'h0280, ref 16'h0300; busy_o high until u_valid_i chn 2.
- Round-robin order: all four rpm_valid_i strobe in the same cycle, u_valid_i returned 2 cycles after each issue -> issue order 0,1,2,3. A second burst after the last grant (channel 3) again issues 0,1,2,3.
- Overrun and stop: two strobes on chn 1 (16'h0010 then 16'h0020) with tready_i = 0 -> ovr_o = 4'b0010, and after tready_i rises the issued fdb is 16'h0020. stop_i[3] = 1 with a strobe on chn 3 -> chn 3 is never issued and ovr_o[3] stays 0.
- Timeout and mismatch: issue chn 0, inject u_valid_i chn 1, withhold chn 0 -> tmo_o pulses exactly TMO_CYCLES cycles after ISSUE, then returns to IDLE and serves the next pending channel.
- Invalid reference channel: tr_valid_i with tr_chn_i = 3'd5 -> no ref register changes, verified by the next issue of each channel.
